// File: rtl/alu_share_sched.sv
// rtl/alu_share_sched.sv - round-robin sharing of one EX-stage ALU between two requesters
module alu_share_sched #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [2:0]        req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [2:0]        req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_id_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_zero_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [2:0]      OP_MUL   = 3'd5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                last_grant;
    logic                grant;
    logic                grant_valid;
    logic                accept;
    logic                exec_done;
    logic                resp_hs;

    logic [DATA_W-1:0]   data1_q;
    logic [DATA_W-1:0]   data2_q;
    logic [2:0]          ctrl_q;
    logic                id_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_zero_q;
    logic                resp_valid_q;

    // Round-robin pick: a lone requester wins outright, a tie goes to the one not served last
    always_comb begin
        grant_valid = req0_valid_i | req1_valid_i;
        grant       = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end
    end

    // Ready is only offered in IDLE and only to the granted requester
    always_comb begin
        req0_ready_o = (state == S_IDLE) && grant_valid && (grant == 1'b0);
        req1_ready_o = (state == S_IDLE) && grant_valid && (grant == 1'b1);
    end

    // Next-state and handshake decode; a multiply stays in EXEC until the ALU has settled
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        exec_done = 1'b0;
        resp_hs   = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((ctrl_q != OP_MUL) || (cnt == CNT_LAST)) begin
                    exec_done = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    resp_hs   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/control registers feeding the ALU; only reloaded on accept so the ALU is quiet otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data1_q <= '0;
            data2_q <= '0;
            ctrl_q  <= '0;
            id_q    <= 1'b0;
        end else if (accept) begin
            id_q <= grant;
            if (grant) begin
                data1_q <= req1_a_i;
                data2_q <= req1_b_i;
                ctrl_q  <= req1_op_i;
            end else begin
                data1_q <= req0_a_i;
                data2_q <= req0_b_i;
                ctrl_q  <= req0_op_i;
            end
        end
    end

    // EXEC cycle counter, cleared on accept and advanced while waiting on a multiply
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == S_EXEC) && !exec_done) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Response capture at the last EXEC cycle, held until the consumer takes it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_data_q  <= '0;
            resp_zero_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else if (exec_done) begin
            resp_data_q  <= alu_data_i;
            resp_zero_q  <= alu_zero_i;
            resp_valid_q <= 1'b1;
        end else if (resp_hs) begin
            resp_valid_q <= 1'b0;
        end
    end

    // Fairness memory: starts at 1 so requester 0 wins the first tie after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
        end else if (resp_hs) begin
            last_grant <= id_q;
        end
    end

    assign alu_data1_o  = data1_q;
    assign alu_data2_o  = data2_q;
    assign alu_ctrl_o   = ctrl_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = id_q;
    assign resp_data_o  = resp_data_q;
    assign resp_zero_o  = resp_zero_q;
    assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// tb/tb_alu_share_sched.sv - self-checking bench for alu_share_sched
module tb_alu_share_sched;

    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0;
    logic              req0_ready;
    logic [2:0]        req0_op = '0;
    logic [DATA_W-1:0] req0_a = '0;
    logic [DATA_W-1:0] req0_b = '0;
    logic              req1_valid = 1'b0;
    logic              req1_ready;
    logic [2:0]        req1_op = '0;
    logic [DATA_W-1:0] req1_a = '0;
    logic [DATA_W-1:0] req1_b = '0;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_data2;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_data;
    logic              alu_zero;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              resp_id;
    logic [DATA_W-1:0] resp_data;
    logic              resp_zero;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_share_sched #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .alu_data1_o  (alu_data1),
        .alu_data2_o  (alu_data2),
        .alu_ctrl_o   (alu_ctrl),
        .alu_data_i   (alu_data),
        .alu_zero_i   (alu_zero),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .resp_zero_o  (resp_zero),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; invalid codes produce 0
    always_comb begin
        case (alu_ctrl)
            3'd1:    alu_data = alu_data1 + alu_data2;
            3'd2:    alu_data = alu_data1 - alu_data2;
            3'd3:    alu_data = alu_data1 & alu_data2;
            3'd4:    alu_data = alu_data1 | alu_data2;
            3'd5:    alu_data = alu_data1 * alu_data2;
            default: alu_data = '0;
        endcase
        alu_zero = (alu_data == '0);
    end

    typedef struct {
        logic              sel;
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] exp_data;
        logic              exp_zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drop_valids();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int waited;
        int lat;
        int exec_cycles;
        int bad_ctrl;
        logic got_ready;
        drop_valids();
        resp_ready = 1'b1;
        if (v.sel) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        #1;
        waited = 0;
        got_ready = v.sel ? req1_ready : req0_ready;
        while (!got_ready && waited < 20) begin
            @(negedge clk);
            waited++;
            got_ready = v.sel ? req1_ready : req0_ready;
        end
        chk($sformatf("vec%0d_ready", idx), got_ready, 1'b1);
        chk($sformatf("vec%0d_ready_wait", idx), waited, 0);
        @(posedge clk);
        #1;
        drop_valids();
        lat = 1;
        exec_cycles = 0;
        bad_ctrl = 0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            exec_cycles++;
            if (alu_ctrl !== v.op) bad_ctrl++;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), lat, (v.op == 3'd5) ? (1 + MUL_LAT) : 2);
        chk($sformatf("vec%0d_exec_cycles", idx), exec_cycles, (v.op == 3'd5) ? MUL_LAT : 1);
        chk($sformatf("vec%0d_ctrl_held", idx), bad_ctrl, 0);
        chk($sformatf("vec%0d_data", idx), resp_data, v.exp_data);
        chk($sformatf("vec%0d_zero", idx), resp_zero, v.exp_zero);
        chk($sformatf("vec%0d_id", idx), resp_id, v.sel);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_resp_cleared", idx), resp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[4];
        logic [DATA_W-1:0] datas[4];
        logic zeros[4];
        int nresp;
        int both_ready;
        int cyc;
        int bp_bad;

        vecs[0] = '{1'b0, 3'd1, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{1'b1, 3'd5, 32'd6,          32'd7,          32'd42,         1'b0};
        vecs[2] = '{1'b0, 3'd1, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[3] = '{1'b1, 3'd7, 32'd3,          32'd4,          32'd0,          1'b1};
        vecs[4] = '{1'b0, 3'd2, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[5] = '{1'b1, 3'd3, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0};
        vecs[6] = '{1'b0, 3'd4, 32'h0000_F000,  32'h0000_000F,  32'h0000_F00F,  1'b0};
        vecs[7] = '{1'b0, 3'd0, 32'd1,          32'd1,          32'd0,          1'b1};
        vecs[8] = '{1'b1, 3'd2, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[9] = '{1'b0, 3'd5, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_alu_ctrl", alu_ctrl, 3'd0);
        chk("rst_alu_data1", alu_data1, 32'd0);
        chk("rst_ready0", req0_ready, 1'b0);
        rst = 1'b0;

        // Round robin with both requesters continuously valid
        @(negedge clk);
        req0_op = 3'd2; req0_a = 32'd9; req0_b = 32'd9;
        req1_op = 3'd1; req1_a = 32'd1; req1_b = 32'd2;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        chk("rr_first_ready0", req0_ready, 1'b1);
        chk("rr_first_ready1", req1_ready, 1'b0);
        nresp = 0; both_ready = 0; cyc = 0;
        while (nresp < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req0_ready && req1_ready) both_ready++;
            if (resp_valid) begin
                ids[nresp] = int'(resp_id);
                datas[nresp] = resp_data;
                zeros[nresp] = resp_zero;
                nresp++;
            end
        end
        drop_valids();
        chk("rr_resp_count", nresp, 4);
        chk("rr_never_both_ready", both_ready, 0);
        chk("rr_id0", ids[0], 0);
        chk("rr_id1", ids[1], 1);
        chk("rr_id2", ids[2], 0);
        chk("rr_id3", ids[3], 1);
        chk("rr_data0", datas[0], 32'd0);
        chk("rr_zero0", zeros[0], 1'b1);
        chk("rr_data1", datas[1], 32'd3);
        chk("rr_zero1", zeros[1], 1'b0);
        repeat (3) @(negedge clk);

        // Table-driven single-op vectors
        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: response held while consumer stalls, no new accepts
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'd2; req0_b = 32'd3;
        #1;
        chk("bp_ready0", req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'd1; req1_b = 32'd2;
        cyc = 0;
        @(negedge clk);
        while (!resp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_resp_arrived", resp_valid, 1'b1);
        bp_bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (resp_valid !== 1'b1 || resp_data !== 32'd5 || resp_id !== 1'b0 ||
                resp_zero !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
                busy !== 1'b1) bp_bad++;
            @(negedge clk);
        end
        chk("bp_held_stable", bp_bad, 0);
        chk("bp_data", resp_data, 32'd5);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", resp_valid, 1'b0);
        chk("bp_next_grant_req1", req1_ready, 1'b1);
        chk("bp_next_grant_not_req0", req0_ready, 1'b0);
        drop_valids();
        @(negedge clk);
        chk("bp_drop_no_accept", busy, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 32'd6; req1_b = 32'd7;
        #1;
        chk("rm_ready1", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        drop_valids();
        @(negedge clk);
        chk("rm_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rm_busy", busy, 1'b0);
        chk("rm_ctrl", alu_ctrl, 3'd0);
        chk("rm_data1", alu_data1, 32'd0);
        chk("rm_data2", alu_data2, 32'd0);
        chk("rm_resp_valid", resp_valid, 1'b0);
        chk("rm_resp_data", resp_data, 32'd0);
        chk("rm_resp_id", resp_id, 1'b0);
        chk("rm_resp_zero", resp_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bp_bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid || busy) bp_bad++;
        end
        chk("rm_no_resp_after", bp_bad, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'd1; req1_op = 3'd1;
        #1;
        chk("rm_restart_req0", req0_ready, 1'b1);
        chk("rm_restart_not_req1", req1_ready, 1'b0);
        drop_valids();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
